// File: rtl/date_counter_leap_if.sv
// Command and status bundle of the BCD calendar counter.
// The master drives commands and load fields; the slave (the counter) drives calendar state and pulses.
interface date_counter_leap_if #(parameter int YEAR_DIGITS = 2);
  logic                     day_tick;
  logic [2:0]               inc_en;
  logic                     load_en;
  logic [7:0]               load_date;
  logic [7:0]               load_month;
  logic [4*YEAR_DIGITS-1:0] load_year;
  logic [7:0]               date;
  logic [7:0]               month;
  logic [4*YEAR_DIGITS-1:0] year;
  logic                     leap;
  logic                     month_carry;
  logic                     year_carry;
  logic                     load_err;

  modport master (
    output day_tick, inc_en, load_en, load_date, load_month, load_year,
    input  date, month, year, leap, month_carry, year_carry, load_err
  );

  modport slave (
    input  day_tick, inc_en, load_en, load_date, load_month, load_year,
    output date, month, year, leap, month_carry, year_carry, load_err
  );
endinterface

// File: rtl/date_counter_leap.sv
// BCD date/month/year counter with exact month lengths and leap-year February.
// Supports a day tick with carries, per-field set-mode increments, and a validated full-date load.
module date_counter_leap #(
  parameter int YEAR_DIGITS = 2
) (
  input  logic clk,
  input  logic rst_n,
  date_counter_leap_if.slave bus
);
  localparam int YW = 4 * YEAR_DIGITS;

  logic [7:0]    date_q, month_q, date_nxt, month_nxt;
  logic [YW-1:0] year_q, year_nxt;
  logic          month_carry_q, year_carry_q, load_err_q;
  logic          month_carry_nxt, year_carry_nxt, load_err_nxt;

  logic [7:0]    cur_len, set_len, set_month, set_date, load_len;
  logic [YW-1:0] year_plus, set_year;
  logic          cur_leap, load_ok;

  function automatic logic div4(input logic [3:0] tens, input logic [3:0] ones);
    if (tens[0]) return (ones == 4'd2) || (ones == 4'd6);
    return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  // Century years fall back to the high digit pair only in the 4-digit build.
  function automatic logic leap_of(input logic [YW-1:0] y);
    logic [15:0] y16;
    y16 = 16'(y);
    if (YEAR_DIGITS == 4 && y16[7:0] == 8'h00) return div4(y16[15:12], y16[11:8]);
    return div4(y16[7:4], y16[3:0]);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] m, input logic lp);
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      8'h02:                      return lp ? 8'h29 : 8'h28;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic          c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [YW+15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < (YW + 16) / 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign cur_leap  = leap_of(year_q);
  assign cur_len   = month_len(month_q, cur_leap);
  assign year_plus = year_inc(year_q);

  // Set mode evaluates the date against the month/year it will land on this edge.
  assign set_month = bus.inc_en[1] ? ((month_q == 8'h12) ? 8'h01 : bcd2_inc(month_q)) : month_q;
  assign set_year  = bus.inc_en[2] ? year_plus : year_q;
  assign set_len   = month_len(set_month, leap_of(set_year));
  assign set_date  = bus.inc_en[0] ? ((date_q >= set_len) ? 8'h01 : bcd2_inc(date_q))
                                   : ((date_q > set_len) ? set_len : date_q);

  assign load_len = month_len(bus.load_month, leap_of(bus.load_year));
  assign load_ok  = digits_ok({bus.load_date, bus.load_month, bus.load_year})
                 && (bus.load_month >= 8'h01) && (bus.load_month <= 8'h12)
                 && (bus.load_date >= 8'h01) && (bus.load_date <= load_len);

  always_comb begin
    date_nxt        = date_q;
    month_nxt       = month_q;
    year_nxt        = year_q;
    month_carry_nxt = 1'b0;
    year_carry_nxt  = 1'b0;
    load_err_nxt    = 1'b0;
    if (bus.load_en) begin
      if (load_ok) begin
        date_nxt  = bus.load_date;
        month_nxt = bus.load_month;
        year_nxt  = bus.load_year;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (bus.day_tick) begin
      if (date_q < cur_len) begin
        date_nxt = bcd2_inc(date_q);
      end else begin
        date_nxt        = 8'h01;
        month_carry_nxt = 1'b1;
        if (month_q == 8'h12) begin
          month_nxt      = 8'h01;
          year_nxt       = year_plus;
          year_carry_nxt = 1'b1;
        end else begin
          month_nxt = bcd2_inc(month_q);
        end
      end
    end else if (|bus.inc_en) begin
      date_nxt  = set_date;
      month_nxt = set_month;
      year_nxt  = set_year;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_q        <= 8'h01;
      month_q       <= 8'h01;
      year_q        <= '0;
      month_carry_q <= 1'b0;
      year_carry_q  <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      date_q        <= date_nxt;
      month_q       <= month_nxt;
      year_q        <= year_nxt;
      month_carry_q <= month_carry_nxt;
      year_carry_q  <= year_carry_nxt;
      load_err_q    <= load_err_nxt;
    end
  end

  assign bus.date        = date_q;
  assign bus.month       = month_q;
  assign bus.year        = year_q;
  assign bus.leap        = cur_leap;
  assign bus.month_carry = month_carry_q;
  assign bus.year_carry  = year_carry_q;
  assign bus.load_err    = load_err_q;
endmodule

// File: tb/tb_date_counter_leap.sv
// Directed bench for the calendar counter, covering both the 4-digit and 2-digit year builds.
// Expected calendar states are hand-computed constants.
module tb_date_counter_leap;
  logic clk;
  logic rst_n;
  int   total_checks;
  int   passed_checks;

  date_counter_leap_if #(.YEAR_DIGITS(4)) bus4 ();
  date_counter_leap_if #(.YEAR_DIGITS(2)) bus2 ();

  date_counter_leap #(.YEAR_DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  date_counter_leap #(.YEAR_DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearInputs();
    bus4.load_en = 1'b0; bus4.day_tick = 1'b0; bus4.inc_en = 3'b000;
    bus4.load_date = 8'h00; bus4.load_month = 8'h00; bus4.load_year = 16'h0000;
    bus2.load_en = 1'b0; bus2.day_tick = 1'b0; bus2.inc_en = 3'b000;
    bus2.load_date = 8'h00; bus2.load_month = 8'h00; bus2.load_year = 8'h00;
  endtask

  // Drives one cycle of commands into the chosen counter, then samples 1 time unit after the edge.
  task automatic applyStimulus(input bit sel2, input logic le, input logic dt, input logic [2:0] inc,
                               input logic [7:0] ld, input logic [7:0] lm, input logic [15:0] ly);
    if (sel2) begin
      bus2.load_en = le; bus2.day_tick = dt; bus2.inc_en = inc;
      bus2.load_date = ld; bus2.load_month = lm; bus2.load_year = ly[7:0];
    end else begin
      bus4.load_en = le; bus4.day_tick = dt; bus4.inc_en = inc;
      bus4.load_date = ld; bus4.load_month = lm; bus4.load_year = ly;
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
  endtask

  task automatic check4(input string tag, input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                        input logic lp, input logic mc, input logic yc, input logic er);
    checkOutput(tag,
      {4'h0, bus4.date, bus4.month, bus4.year, bus4.leap, bus4.month_carry, bus4.year_carry, bus4.load_err},
      {4'h0, d, m, y, lp, mc, yc, er});
  endtask

  task automatic check2(input string tag, input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                        input logic lp, input logic mc, input logic yc, input logic er);
    checkOutput(tag,
      {12'h000, bus2.date, bus2.month, bus2.year, bus2.leap, bus2.month_carry, bus2.year_carry, bus2.load_err},
      {12'h000, d, m, y, lp, mc, yc, er});
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n = 1'b0;
    clearInputs();
    #12;
    check4("reset4", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check2("reset2", 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("first_tick", 8'h02, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h28, 8'h02, 16'h2023);
    check4("load_2023", 8'h28, 8'h02, 16'h2023, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("feb_end_2023", 8'h01, 8'h03, 16'h2023, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("carry_drops", 8'h01, 8'h03, 16'h2023, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h28, 8'h02, 16'h2024);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("feb29_2024", 8'h29, 8'h02, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("mar1_2024", 8'h01, 8'h03, 16'h2024, 1'b1, 1'b1, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h28, 8'h02, 16'h1900);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("century_1900", 8'h01, 8'h03, 16'h1900, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 3'b000, 8'h28, 8'h02, 16'h2000);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("century_2000", 8'h29, 8'h02, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h31, 8'h12, 16'h9999);
    check4("load_9999", 8'h31, 8'h12, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("wrap_9999", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h29, 8'h02, 16'h2023);
    check4("rej_feb29_2023", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 3'b000, 8'h31, 8'h04, 16'h2024);
    check4("rej_apr31", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 3'b000, 8'h10, 8'h13, 16'h2024);
    check4("rej_month13", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1, 0, 3'b000, 8'h1A, 8'h01, 16'h2024);
    check4("rej_digit_a", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("err_drops", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h31, 8'h01, 16'h2023);
    applyStimulus(0, 0, 0, 3'b010, 8'h00, 8'h00, 16'h0000);
    check4("inc_month_clamp", 8'h28, 8'h02, 16'h2023, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 3'b000, 8'h10, 8'h05, 16'h2024);
    check4("load_beats_tick", 8'h10, 8'h05, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 3'b111, 8'h00, 8'h00, 16'h0000);
    check4("tick_beats_inc", 8'h11, 8'h05, 16'h2024, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 3'b101, 8'h00, 8'h00, 16'h0000);
    check4("inc_date_year", 8'h12, 8'h05, 16'h2025, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 3'b000, 8'h29, 8'h02, 16'h2024);
    applyStimulus(0, 0, 0, 3'b100, 8'h00, 8'h00, 16'h0000);
    check4("inc_year_clamp", 8'h28, 8'h02, 16'h2025, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 3'b001, 8'h00, 8'h00, 16'h0000);
    check4("inc_date_wrap", 8'h01, 8'h02, 16'h2025, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1, 1, 0, 3'b000, 8'h31, 8'h12, 16'h0099);
    check2("load_99", 8'h31, 8'h12, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check2("wrap_99", 8'h01, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 3'b000, 8'h28, 8'h02, 16'h0000);
    applyStimulus(1, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check2("feb29_00", 8'h29, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    applyStimulus(0, 1, 0, 3'b000, 8'h31, 8'h01, 16'h2024);
    applyStimulus(0, 0, 1, 3'b000, 8'h00, 8'h00, 16'h0000);
    check4("jan_roll", 8'h01, 8'h02, 16'h2024, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check4("async_reset4", 8'h01, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check2("async_reset2", 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule
